// File: rtl/clk_seq_pkg.sv
// Shared types and reset constants for the clock-lock bring-up sequencer.
// Output decode lives here so the state-to-output mapping is defined once.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_RST_DCM,
    ST_WAIT_LOCK,
    ST_RST_DCM2X,
    ST_WAIT_LOCK2X,
    ST_RST_IDLY,
    ST_WAIT_RDY,
    ST_RUN
  } seq_state_t;

  typedef struct packed {
    logic dcm_rst;
    logic dcm2x_rst;
    logic idelay_rst;
    logic app_rst;
    logic seq_done;
  } seq_outs_t;

  localparam seq_state_t STATE_RST  = ST_RST_DCM;
  localparam seq_outs_t  OUTS_RST   = '{dcm_rst: 1'b1, dcm2x_rst: 1'b1, idelay_rst: 1'b1,
                                        app_rst: 1'b1, seq_done: 1'b0};
  localparam logic [7:0] RETRY_RST  = 8'd0;
  localparam logic [7:0] RELOCK_RST = 8'd0;
  localparam logic [7:0] RELOCK_MAX = 8'hFF;

  function automatic seq_outs_t outs_for(seq_state_t st);
    seq_outs_t o;
    o.dcm_rst    = (st == ST_RST_DCM);
    o.dcm2x_rst  = (st == ST_RST_DCM) || (st == ST_WAIT_LOCK) || (st == ST_RST_DCM2X);
    o.idelay_rst = (st == ST_RST_IDLY);
    o.app_rst    = (st != ST_RUN);
    o.seq_done   = (st == ST_RUN);
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_lock_sequencer.sv
// Brings up a primary DCM, a cascaded 2x DCM and an IDELAYCTRL in order,
// retrying on timeout and restarting on lock loss; all outputs registered.
module clk_lock_sequencer
  import clk_seq_pkg::*;
#(
  parameter int RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int IDLY_RST_CYCLES = 8,
  parameter int MAX_RETRIES     = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       dcm_locked,
  input  logic       dcm2x_locked,
  input  logic       idelay_rdy,
  output logic       dcm_rst,
  output logic       dcm2x_rst,
  output logic       idelay_rst,
  output logic       app_rst,
  output logic       seq_done,
  output logic       lock_err,
  output logic [7:0] relock_count
);

  localparam logic [15:0] CNT_RST   = 16'(RST_CYCLES);
  localparam logic [15:0] CNT_LOCK  = 16'(LOCK_TIMEOUT);
  localparam logic [15:0] CNT_IDLY  = 16'(IDLY_RST_CYCLES);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRIES);

  logic dcm_lk, dcm2x_lk, rdy_lk;

  sync_2ff u_sync_dcm   (.clk(sys_clk), .rst(rst), .d(dcm_locked),   .q(dcm_lk));
  sync_2ff u_sync_dcm2x (.clk(sys_clk), .rst(rst), .d(dcm2x_locked), .q(dcm2x_lk));
  sync_2ff u_sync_rdy   (.clk(sys_clk), .rst(rst), .d(idelay_rdy),   .q(rdy_lk));

  seq_state_t  state, state_nxt;
  seq_outs_t   outs, outs_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [7:0]  retry, retry_nxt, relock_nxt;
  logic        lock_err_nxt, retry_inc, expired;

  assign expired = (cnt == 16'd1);

  // Lock-loss branches sit ahead of the timeout branches so loss wins a tie.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt  = state;
    cnt_nxt    = cnt - 16'd1;
    retry_nxt  = retry;
    relock_nxt = relock_count;
    retry_inc  = 1'b0;
    case (state)
      ST_RST_DCM: if (expired) begin
        state_nxt = ST_WAIT_LOCK;   cnt_nxt = CNT_LOCK;
      end
      ST_WAIT_LOCK: if (dcm_lk) begin
        state_nxt = ST_RST_DCM2X;   cnt_nxt = CNT_RST;
      end else if (expired) begin
        state_nxt = ST_RST_DCM;     cnt_nxt = CNT_RST;  retry_inc = 1'b1;
      end
      ST_RST_DCM2X: if (expired) begin
        state_nxt = ST_WAIT_LOCK2X; cnt_nxt = CNT_LOCK;
      end
      ST_WAIT_LOCK2X: if (!dcm_lk) begin
        state_nxt = ST_RST_DCM;     cnt_nxt = CNT_RST;
      end else if (dcm2x_lk) begin
        state_nxt = ST_RST_IDLY;    cnt_nxt = CNT_IDLY;
      end else if (expired) begin
        state_nxt = ST_RST_DCM;     cnt_nxt = CNT_RST;  retry_inc = 1'b1;
      end
      ST_RST_IDLY: if (expired) begin
        state_nxt = ST_WAIT_RDY;    cnt_nxt = CNT_LOCK;
      end
      ST_WAIT_RDY: if (!dcm_lk || !dcm2x_lk) begin
        state_nxt = ST_RST_DCM;     cnt_nxt = CNT_RST;
      end else if (rdy_lk) begin
        state_nxt = ST_RUN;
      end else if (expired) begin
        state_nxt = ST_RST_IDLY;    cnt_nxt = CNT_IDLY; retry_inc = 1'b1;
      end
      ST_RUN: begin
        cnt_nxt = cnt;
        if (!dcm_lk || !dcm2x_lk) begin
          state_nxt = ST_RST_DCM;   cnt_nxt = CNT_RST;
          if (relock_count != RELOCK_MAX) relock_nxt = relock_count + 8'd1;
        end else if (!rdy_lk) begin
          state_nxt = ST_RST_IDLY;  cnt_nxt = CNT_IDLY;
        end
      end
      default: begin
        state_nxt = ST_RST_DCM;     cnt_nxt = CNT_RST;
      end
    endcase
    if (retry_inc && (retry != 8'hFF)) retry_nxt = retry + 8'd1;
    if ((state_nxt == ST_RUN) && (state != ST_RUN)) retry_nxt = RETRY_RST;
    lock_err_nxt = lock_err | (retry_inc && (retry_nxt >= RETRY_MAX));
    // Decoding from the next state keeps outputs registered yet aligned with the state.
    outs_nxt = outs_for(state_nxt);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state        <= STATE_RST;
      cnt          <= CNT_RST;
      retry        <= RETRY_RST;
      lock_err     <= 1'b0;
      relock_count <= RELOCK_RST;
      outs         <= OUTS_RST;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      retry        <= retry_nxt;
      lock_err     <= lock_err_nxt;
      relock_count <= relock_nxt;
      outs         <= outs_nxt;
    end
  end

  assign dcm_rst    = outs.dcm_rst;
  assign dcm2x_rst  = outs.dcm2x_rst;
  assign idelay_rst = outs.idelay_rst;
  assign app_rst    = outs.app_rst;
  assign seq_done   = outs.seq_done;

endmodule
